// File: rtl/store_bus_sequencer_pkg.sv
// Shared definitions for the store bus sequencer (package riscv_defines).
// Optional feature macro used by the sequencer: KIANV_MISALIGNED_STORE_EN.
package riscv_defines;

   typedef enum logic [1:0] {
      STORE_OP_SB = 2'b00,
      STORE_OP_SH = 2'b01,
      STORE_OP_SW = 2'b10
   } StoreOp_t;

   typedef enum logic [1:0] {
      SEQ_IDLE   = 2'd0,
      SEQ_ISSUE0 = 2'd1,
      SEQ_ISSUE1 = 2'd2
   } StoreSeqState_t;

   localparam int STORE_TIMEOUT_DEFAULT = 0;

   // Byte-enable pattern of a store before lane shifting; unknown encodings act as SB.
   function automatic logic [3:0] store_base_mask(input StoreOp_t op);
      case (op)
         STORE_OP_SH: return 4'b0011;
         STORE_OP_SW: return 4'b1111;
         default:     return 4'b0001;
      endcase
   endfunction

endpackage

// File: rtl/store_bus_sequencer_if.sv
// Request and data-memory write bus of the store sequencer.
// Handshakes: a request moves on a rising edge with req_valid && req_ready;
// a bus write moves on a rising edge with mem_valid && mem_ready, and
// mem_addr/mem_wdata/mem_wstrb hold steady while mem_valid is high and
// mem_ready is low. dbg_state mirrors the sequencer FSM state.
interface store_bus_sequencer_if;
   import riscv_defines::*;

   logic           req_valid;
   logic           req_ready;
   StoreOp_t       req_op;
   logic [31:0]    req_addr;
   logic [31:0]    req_data;
   logic           mem_valid;
   logic           mem_ready;
   logic [31:0]    mem_addr;
   logic [31:0]    mem_wdata;
   logic [3:0]     mem_wstrb;
   logic           done;
   logic           err_misaligned;
   logic           err_timeout;
   logic           busy;
   StoreSeqState_t dbg_state;

   // Sequencer side: receives requests, drives the write bus and status.
   modport master (
      input  req_valid, req_op, req_addr, req_data, mem_ready,
      output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output done, err_misaligned, err_timeout, busy, dbg_state
   );

   // Environment side: pipeline and memory.
   modport slave (
      output req_valid, req_op, req_addr, req_data, mem_ready,
      input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  done, err_misaligned, err_timeout, busy, dbg_state
   );

endinterface

// File: rtl/store_bus_sequencer_lane_align.sv
// store_lane_align: splits a store into one or two word-aligned bus beats.
module store_lane_align
   import riscv_defines::*;
(
   input  StoreOp_t    i_op,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_data,
   output logic [3:0]  o_b0_wstrb,
   output logic [31:0] o_b0_wdata,
   output logic [31:0] o_b0_addr,
   output logic [3:0]  o_b1_wstrb,
   output logic [31:0] o_b1_wdata,
   output logic [31:0] o_b1_addr,
   output logic        o_has_beat1,
   output logic        o_misaligned
);

   logic [1:0]  w_off;
   logic [7:0]  w_mask8;
   logic [63:0] w_data64;

   assign w_off    = i_addr[1:0];
   // Shift across two words so that bytes spilling past the word land in beat1.
   assign w_mask8  = {4'b0000, store_base_mask(i_op)} << w_off;
   assign w_data64 = {32'h0000_0000, i_data} << {w_off, 3'b000};

   assign o_b0_wstrb  = w_mask8[3:0];
   assign o_b0_wdata  = w_data64[31:0];
   assign o_b0_addr   = {i_addr[31:2], 2'b00};
   assign o_b1_wstrb  = w_mask8[7:4];
   assign o_b1_wdata  = w_data64[63:32];
   // Wraps naturally modulo 2^32.
   assign o_b1_addr   = o_b0_addr + 32'd4;
   assign o_has_beat1 = |w_mask8[7:4];

   assign o_misaligned = ((i_op == STORE_OP_SH) && w_off[0]) ||
                         ((i_op == STORE_OP_SW) && (w_off != 2'b00));

endmodule

// File: rtl/store_bus_sequencer.sv
// store_bus_sequencer: puts store operations on the data-memory write bus.
// Macro KIANV_MISALIGNED_STORE_EN enables execution of misaligned stores
// (two beats when crossing a word); without it they are rejected.
module store_bus_sequencer
   import riscv_defines::*;
#(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = STORE_TIMEOUT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  resetn,
   store_bus_sequencer_if.master bus
);

   logic [3:0]      w_b0_wstrb, w_b1_wstrb;
   logic [31:0]     w_b0_wdata, w_b1_wdata, w_b0_addr, w_b1_addr;
   logic            w_has_beat1, w_misaligned;

   store_lane_align u_align (
      .i_op         (bus.req_op),
      .i_addr       (bus.req_addr),
      .i_data       (bus.req_data),
      .o_b0_wstrb   (w_b0_wstrb),
      .o_b0_wdata   (w_b0_wdata),
      .o_b0_addr    (w_b0_addr),
      .o_b1_wstrb   (w_b1_wstrb),
      .o_b1_wdata   (w_b1_wdata),
      .o_b1_addr    (w_b1_addr),
      .o_has_beat1  (w_has_beat1),
      .o_misaligned (w_misaligned)
   );

   StoreSeqState_t  r_state, w_state_nxt;
   logic            r_mem_valid, w_mem_valid_nxt;
   logic [XLEN-1:0] r_mem_addr, w_mem_addr_nxt;
   logic [XLEN-1:0] r_mem_wdata, w_mem_wdata_nxt;
   logic [3:0]      r_mem_wstrb, w_mem_wstrb_nxt;
   logic            r_req_ready, r_busy;
   logic            r_done, w_done_nxt;
   logic            r_err_timeout, w_err_timeout_nxt;
   logic [31:0]     r_tmo_cnt, w_tmo_cnt_nxt;
   logic            w_accept, w_tmo_hit;

   assign w_accept  = bus.req_valid && r_req_ready;
   // Give up on the beat once it has waited TIMEOUT_CYCLES cycles in total.
   assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

`ifdef KIANV_MISALIGNED_STORE_EN
   // Second beat is captured at accept time because req_* may change afterwards.
   logic            r_has_b1;
   logic [31:0]     r_b1_addr, r_b1_wdata;
   logic [3:0]      r_b1_wstrb;
   logic            w_unused_align;
   assign w_unused_align = w_misaligned;
`else
   logic            r_err_mis, w_err_mis_nxt;
   logic            w_unused_align;
   assign w_unused_align = ^{w_b1_addr, w_b1_wdata, w_b1_wstrb, w_has_beat1};
`endif

   // Next-state and next-output decode of the sequencer FSM.
   always_comb begin
      w_state_nxt       = r_state;
      w_mem_valid_nxt   = r_mem_valid;
      w_mem_addr_nxt    = r_mem_addr;
      w_mem_wdata_nxt   = r_mem_wdata;
      w_mem_wstrb_nxt   = r_mem_wstrb;
      w_done_nxt        = 1'b0;
      w_err_timeout_nxt = 1'b0;
      w_tmo_cnt_nxt     = r_tmo_cnt;
`ifndef KIANV_MISALIGNED_STORE_EN
      w_err_mis_nxt     = 1'b0;
`endif
      case (r_state)
         SEQ_IDLE: begin
            if (w_accept) begin
`ifndef KIANV_MISALIGNED_STORE_EN
               if (w_misaligned) begin
                  w_err_mis_nxt = 1'b1;
               end else
`endif
               begin
                  w_state_nxt     = SEQ_ISSUE0;
                  w_mem_valid_nxt = 1'b1;
                  w_mem_addr_nxt  = w_b0_addr;
                  w_mem_wdata_nxt = w_b0_wdata;
                  w_mem_wstrb_nxt = w_b0_wstrb;
                  w_tmo_cnt_nxt   = 32'd0;
               end
            end
         end
         SEQ_ISSUE0, SEQ_ISSUE1: begin
            if (bus.mem_ready) begin
               w_tmo_cnt_nxt = 32'd0;
`ifdef KIANV_MISALIGNED_STORE_EN
               if ((r_state == SEQ_ISSUE0) && r_has_b1) begin
                  w_state_nxt     = SEQ_ISSUE1;
                  w_mem_addr_nxt  = r_b1_addr;
                  w_mem_wdata_nxt = r_b1_wdata;
                  w_mem_wstrb_nxt = r_b1_wstrb;
               end else
`endif
               begin
                  w_state_nxt     = SEQ_IDLE;
                  w_mem_valid_nxt = 1'b0;
                  w_done_nxt      = 1'b1;
               end
            end else if (w_tmo_hit) begin
               // Abandon the store; an already written beat0 is not undone.
               w_state_nxt       = SEQ_IDLE;
               w_mem_valid_nxt   = 1'b0;
               w_err_timeout_nxt = 1'b1;
               w_tmo_cnt_nxt     = 32'd0;
            end else begin
               w_tmo_cnt_nxt = r_tmo_cnt + 32'd1;
            end
         end
         default: begin
            w_state_nxt     = SEQ_IDLE;
            w_mem_valid_nxt = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset drops the bus request immediately.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= SEQ_IDLE;
         r_req_ready   <= 1'b1;
         r_busy        <= 1'b0;
         r_mem_valid   <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_mem_wstrb   <= 4'b0000;
         r_done        <= 1'b0;
         r_err_timeout <= 1'b0;
         r_tmo_cnt     <= 32'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_req_ready   <= (w_state_nxt == SEQ_IDLE);
         r_busy        <= (w_state_nxt != SEQ_IDLE);
         r_mem_valid   <= w_mem_valid_nxt;
         r_mem_addr    <= w_mem_addr_nxt;
         r_mem_wdata   <= w_mem_wdata_nxt;
         r_mem_wstrb   <= w_mem_wstrb_nxt;
         r_done        <= w_done_nxt;
         r_err_timeout <= w_err_timeout_nxt;
         r_tmo_cnt     <= w_tmo_cnt_nxt;
      end
   end

`ifdef KIANV_MISALIGNED_STORE_EN
   // Capture the second beat of an accepted store.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_has_b1   <= 1'b0;
         r_b1_addr  <= 32'd0;
         r_b1_wdata <= 32'd0;
         r_b1_wstrb <= 4'b0000;
      end else if (w_accept) begin
         r_has_b1   <= w_has_beat1;
         r_b1_addr  <= w_b1_addr;
         r_b1_wdata <= w_b1_wdata;
         r_b1_wstrb <= w_b1_wstrb;
      end
   end
   assign bus.err_misaligned = 1'b0;
`else
   // Rejection pulse for misaligned stores.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_err_mis <= 1'b0;
      else         r_err_mis <= w_err_mis_nxt;
   end
   assign bus.err_misaligned = r_err_mis;
`endif

   assign bus.req_ready   = r_req_ready;
   assign bus.busy        = r_busy;
   assign bus.mem_valid   = r_mem_valid;
   assign bus.mem_addr    = r_mem_addr;
   assign bus.mem_wdata   = r_mem_wdata;
   assign bus.mem_wstrb   = r_mem_wstrb;
   assign bus.done        = r_done;
   assign bus.err_timeout = r_err_timeout;
   assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_store_bus_sequencer.sv
// Directed bench for store_bus_sequencer: dut0 without timeout, dut4 with
// TIMEOUT_CYCLES=4. Optional feature macro: KIANV_MISALIGNED_STORE_EN.
module tb_store_bus_sequencer;
   import riscv_defines::*;

   logic clk = 1'b0;
   logic resetn;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   store_bus_sequencer_if bus0 ();
   store_bus_sequencer_if bus4 ();

   store_bus_sequencer #(.XLEN(32), .TIMEOUT_CYCLES(0)) dut0 (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus0)
   );

   store_bus_sequencer #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut4 (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge so registered outputs have settled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request to dut0; returns one cycle after the accepting edge.
   task automatic send0(input StoreOp_t op, input logic [31:0] addr, input logic [31:0] data);
      bus0.req_valid = 1'b1;
      bus0.req_op    = op;
      bus0.req_addr  = addr;
      bus0.req_data  = data;
      tick();
      bus0.req_valid = 1'b0;
   endtask

   // Check one beat presented by dut0.
   task automatic beat0(input string tag, input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata);
      check({tag, "_valid"}, 32'(bus0.mem_valid), 32'd1);
      check({tag, "_addr"},  bus0.mem_addr, addr);
      check({tag, "_wstrb"}, 32'(bus0.mem_wstrb), 32'(strb));
      check({tag, "_wdata"}, bus0.mem_wdata, wdata);
      check({tag, "_rdy"},   32'(bus0.req_ready), 32'd0);
      check({tag, "_done"},  32'(bus0.done), 32'd0);
   endtask

   // Check the completion pulse of dut0 and the return to idle.
   task automatic done0(input string tag);
      check({tag, "_done"},  32'(bus0.done), 32'd1);
      check({tag, "_valid"}, 32'(bus0.mem_valid), 32'd0);
      check({tag, "_rdy"},   32'(bus0.req_ready), 32'd1);
      check({tag, "_busy"},  32'(bus0.busy), 32'd0);
      tick();
      check({tag, "_done_clr"}, 32'(bus0.done), 32'd0);
   endtask

   initial begin
      resetn         = 1'b0;
      bus0.req_valid = 1'b0;
      bus0.req_op    = STORE_OP_SB;
      bus0.req_addr  = 32'd0;
      bus0.req_data  = 32'd0;
      bus0.mem_ready = 1'b0;
      bus4.req_valid = 1'b0;
      bus4.req_op    = STORE_OP_SB;
      bus4.req_addr  = 32'd0;
      bus4.req_data  = 32'd0;
      bus4.mem_ready = 1'b0;

      // Reset state.
      repeat (3) tick();
      check("rst_rdy",   32'(bus0.req_ready), 32'd1);
      check("rst_valid", 32'(bus0.mem_valid), 32'd0);
      check("rst_addr",  bus0.mem_addr, 32'd0);
      check("rst_wdata", bus0.mem_wdata, 32'd0);
      check("rst_wstrb", 32'(bus0.mem_wstrb), 32'd0);
      check("rst_flags", 32'({bus0.done, bus0.err_misaligned, bus0.err_timeout, bus0.busy}), 32'd0);
      check("rst_state", 32'(bus0.dbg_state), 32'(SEQ_IDLE));
      check("rst4_rdy",  32'(bus4.req_ready), 32'd1);
      resetn = 1'b1;
      tick();

      // 1: SB at byte 3, memory ready at once.
      bus0.mem_ready = 1'b1;
      send0(STORE_OP_SB, 32'h0000_1003, 32'h0000_00A5);
      beat0("sb3", 32'h0000_1000, 4'b1000, 32'hA500_0000);
      check("sb3_state", 32'(bus0.dbg_state), 32'(SEQ_ISSUE0));
      tick();
      done0("sb3");

      // 2: SW aligned, memory stalls three cycles.
      bus0.mem_ready = 1'b0;
      send0(STORE_OP_SW, 32'h0000_2000, 32'h1122_3344);
      beat0("sw_w0", 32'h0000_2000, 4'b1111, 32'h1122_3344);
      for (int i = 0; i < 3; i++) begin
         tick();
         beat0("sw_wait", 32'h0000_2000, 4'b1111, 32'h1122_3344);
      end
      bus0.mem_ready = 1'b1;
      tick();
      done0("sw");

      // Unknown op encoding behaves as SB.
      send0(StoreOp_t'(2'b11), 32'h0000_3001, 32'h0000_0077);
      beat0("unk", 32'h0000_3000, 4'b0010, 32'h0000_7700);
      tick();
      done0("unk");

      // Aligned halfword in the upper lanes is a single beat in every build.
      send0(STORE_OP_SH, 32'h0000_4002, 32'h0000_BEEF);
      beat0("sh2", 32'h0000_4000, 4'b1100, 32'hBEEF_0000);
      tick();
      done0("sh2");

`ifdef KIANV_MISALIGNED_STORE_EN
      // 3: word-crossing SW in two beats.
      send0(STORE_OP_SW, 32'h0000_2002, 32'hAABB_CCDD);
      beat0("msw_b0", 32'h0000_2000, 4'b1100, 32'hCCDD_0000);
      tick();
      beat0("msw_b1", 32'h0000_2004, 4'b0011, 32'h0000_AABB);
      check("msw_state", 32'(bus0.dbg_state), 32'(SEQ_ISSUE1));
      tick();
      done0("msw");

      // 4: SH at the top of the address space wraps to address 0.
      send0(STORE_OP_SH, 32'hFFFF_FFFF, 32'h1234_BEEF);
      beat0("wrap_b0", 32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000);
      tick();
      beat0("wrap_b1", 32'h0000_0000, 4'b0001, 32'h0012_34BE);
      tick();
      done0("wrap");

      // In-word misaligned SH is one beat and never flagged.
      send0(STORE_OP_SH, 32'h0000_5001, 32'h0000_1234);
      beat0("sh1", 32'h0000_5000, 4'b0110, 32'h0012_3400);
      check("sh1_mis", 32'(bus0.err_misaligned), 32'd0);
      tick();
      done0("sh1");
`else
      // 3: misaligned SW rejected without bus activity.
      send0(STORE_OP_SW, 32'h0000_2002, 32'hAABB_CCDD);
      check("mis_err",   32'(bus0.err_misaligned), 32'd1);
      check("mis_valid", 32'(bus0.mem_valid), 32'd0);
      check("mis_rdy",   32'(bus0.req_ready), 32'd1);
      check("mis_done",  32'(bus0.done), 32'd0);
      tick();
      check("mis_clr",   32'(bus0.err_misaligned), 32'd0);
      check("mis_valid2", 32'(bus0.mem_valid), 32'd0);

      // 4: SH at byte 3 is rejected as well.
      send0(STORE_OP_SH, 32'hFFFF_FFFF, 32'h1234_BEEF);
      check("mis_sh_err",   32'(bus0.err_misaligned), 32'd1);
      check("mis_sh_valid", 32'(bus0.mem_valid), 32'd0);
      tick();
      check("mis_sh_clr",   32'(bus0.err_misaligned), 32'd0);
`endif

      // 5: timeout after four waiting cycles on dut4.
      bus4.req_valid = 1'b1;
      bus4.req_op    = STORE_OP_SW;
      bus4.req_addr  = 32'h0000_6000;
      bus4.req_data  = 32'hCAFE_F00D;
      tick();
      bus4.req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("tmo_valid", 32'(bus4.mem_valid), 32'd1);
         check("tmo_early", 32'(bus4.err_timeout), 32'd0);
         tick();
      end
      check("tmo_err",   32'(bus4.err_timeout), 32'd1);
      check("tmo_valid_off", 32'(bus4.mem_valid), 32'd0);
      check("tmo_done",  32'(bus4.done), 32'd0);
      check("tmo_rdy",   32'(bus4.req_ready), 32'd1);
      check("tmo_state", 32'(bus4.dbg_state), 32'(SEQ_IDLE));
      tick();
      check("tmo_clr",   32'(bus4.err_timeout), 32'd0);
      check("tmo_done2", 32'(bus4.done), 32'd0);

      // 6: reset in the middle of a transfer.
`ifdef KIANV_MISALIGNED_STORE_EN
      bus0.mem_ready = 1'b1;
      send0(STORE_OP_SW, 32'h0000_2002, 32'hAABB_CCDD);
      tick();
      check("rmid_state", 32'(bus0.dbg_state), 32'(SEQ_ISSUE1));
`else
      bus0.mem_ready = 1'b0;
      send0(STORE_OP_SW, 32'h0000_7000, 32'h0BAD_0BAD);
      check("rmid_state", 32'(bus0.dbg_state), 32'(SEQ_ISSUE0));
`endif
      bus0.mem_ready = 1'b0;
      resetn = 1'b0;
      #1;
      check("rmid_valid", 32'(bus0.mem_valid), 32'd0);
      check("rmid_idle",  32'(bus0.dbg_state), 32'(SEQ_IDLE));
      repeat (2) tick();
      resetn = 1'b1;
      tick();
      check("rpost_rdy",   32'(bus0.req_ready), 32'd1);
      check("rpost_state", 32'(bus0.dbg_state), 32'(SEQ_IDLE));
      check("rpost_busy",  32'(bus0.busy), 32'd0);
      check("rpost_done",  32'(bus0.done), 32'd0);
      tick();
      check("rpost_valid", 32'(bus0.mem_valid), 32'd0);
      check("rpost_done2", 32'(bus0.done), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
